// File: rtl/riscv_mpsoc_pkg.sv
// Shared types and constants for the MPSoC core, including the
// instruction prefetch buffer entry layout.
package riscv_mpsoc_pkg;

    localparam int PF_XLEN          = 64;
    localparam int PF_PARCEL_SIZE   = 32;
    localparam int PF_DEPTH_DEFAULT = 4;

    // addi x0, x0, 0
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    // One prefetch queue slot. The filled flag lives outside this struct
    // so a flush can clear every slot without touching the payload.
    typedef struct packed {
        logic [PF_PARCEL_SIZE-1:0] parcel;
        logic [PF_XLEN-1:0]        pc;
        logic                      misaligned;
        logic                      fault;
    } pf_entry_t;

endpackage

// File: rtl/riscv_if_prefetch_ram.sv
// Prefetch queue storage: request-time fields are written by the alloc
// port, response-time fields by the fill port, and the head is read async.
module riscv_if_prefetch_ram
    import riscv_mpsoc_pkg::*;
#(
    parameter int DEPTH = PF_DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      alloc_we,
    input  logic [AW-1:0]             alloc_idx,
    input  logic [PF_XLEN-1:0]        alloc_pc,
    input  logic                      alloc_misaligned,
    input  logic                      fill_we,
    input  logic [AW-1:0]             fill_idx,
    input  logic [PF_PARCEL_SIZE-1:0] fill_parcel,
    input  logic                      fill_fault,
    input  logic [AW-1:0]             rd_idx,
    output pf_entry_t                 rd_entry
);

    pf_entry_t mem_q [DEPTH];
    pf_entry_t mem_d [DEPTH];

    // Alloc and fill never target the same slot, and touch disjoint fields anyway.
    always_comb begin
        mem_d = mem_q;
        if (alloc_we) begin
            mem_d[alloc_idx].pc         = alloc_pc;
            mem_d[alloc_idx].misaligned = alloc_misaligned;
        end
        if (fill_we) begin
            mem_d[fill_idx].parcel = fill_parcel;
            mem_d[fill_idx].fault  = fill_fault;
        end
    end

    // Storage register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_entry = mem_q[rd_idx];

endmodule

// File: rtl/riscv_if_prefetch.sv
// Instruction parcel prefetch buffer: issues in-order fetches at the
// fetch stage's next PC, queues tagged responses and discards stale
// responses that were in flight when the fetch stream was redirected.
module riscv_if_prefetch
    import riscv_mpsoc_pkg::*;
#(
    parameter int XLEN        = PF_XLEN,
    parameter int PARCEL_SIZE = PF_PARCEL_SIZE,
    parameter int DEPTH       = PF_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [XLEN-1:0]          if_nxt_pc,
    input  logic                     if_stall,
    input  logic                     if_flush,
    output logic                     if_stall_nxt_pc,
    output logic [PARCEL_SIZE-1:0]   if_parcel,
    output logic [XLEN-1:0]          if_parcel_pc,
    output logic [PARCEL_SIZE/16-1:0] if_parcel_valid,
    output logic                     if_parcel_misaligned,
    output logic                     if_parcel_page_fault,
    output logic                     mem_req,
    output logic [XLEN-1:0]          mem_adr,
    input  logic                     mem_ack,
    input  logic                     mem_rvalid,
    input  logic [PARCEL_SIZE-1:0]   mem_rdata,
    input  logic                     mem_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // The entry struct is sized by the package, so the widths must agree.
    if (XLEN != PF_XLEN || PARCEL_SIZE != PF_PARCEL_SIZE ||
        DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_chk
        $error("riscv_if_prefetch: unsupported parameter set");
    end

    logic [PW-1:0]    alloc_ptr_q, alloc_ptr_d;
    logic [PW-1:0]    fill_ptr_q,  fill_ptr_d;
    logic [PW-1:0]    rd_ptr_q,    rd_ptr_d;
    logic [PW-1:0]    discard_cnt_q, discard_cnt_d;
    logic [DEPTH-1:0] filled_q,    filled_d;

    logic [PW-1:0]    occupancy, inflight;
    logic [PW:0]      budget;
    logic             issue, resp_drop, resp_fill, head_ok, pop;
    logic [AW-1:0]    alloc_idx, fill_idx, head_idx;
    pf_entry_t        head;

    assign occupancy = alloc_ptr_q - rd_ptr_q;
    assign inflight  = alloc_ptr_q - fill_ptr_q;
    assign alloc_idx = alloc_ptr_q[AW-1:0];
    assign fill_idx  = fill_ptr_q[AW-1:0];
    assign head_idx  = rd_ptr_q[AW-1:0];

    // Slots still owed to stale responses count against capacity, so a
    // discarded response can never land on a freshly allocated slot.
    assign budget    = {1'b0, occupancy} + {1'b0, discard_cnt_q};
    assign mem_req   = rstn & ~if_flush & (budget < (PW+1)'(DEPTH));
    assign mem_adr   = {if_nxt_pc[XLEN-1:2], 2'b00};
    assign issue     = mem_req & mem_ack;
    assign if_stall_nxt_pc = ~issue;

    assign resp_drop = mem_rvalid & (discard_cnt_q != '0);
    assign resp_fill = mem_rvalid & (discard_cnt_q == '0);

    assign head_ok   = (occupancy != '0) & filled_q[head_idx] & ~if_flush;
    assign pop       = head_ok & ~if_stall;

    // Pointer, filled-bit and discard bookkeeping; a flush overrides everything.
    always_comb begin
        alloc_ptr_d   = alloc_ptr_q;
        fill_ptr_d    = fill_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        discard_cnt_d = discard_cnt_q;
        filled_d      = filled_q;
        if (if_flush) begin
            alloc_ptr_d   = '0;
            fill_ptr_d    = '0;
            rd_ptr_d      = '0;
            filled_d      = '0;
            // Everything still outstanding becomes stale, minus the one
            // response (stale or not) consumed this cycle.
            discard_cnt_d = discard_cnt_q + inflight - PW'(mem_rvalid);
        end else begin
            if (issue) begin
                alloc_ptr_d         = alloc_ptr_q + 1'b1;
                filled_d[alloc_idx] = 1'b0;
            end
            if (resp_drop) begin
                discard_cnt_d = discard_cnt_q - 1'b1;
            end
            if (resp_fill) begin
                filled_d[fill_idx] = 1'b1;
                fill_ptr_d         = fill_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            alloc_ptr_q   <= '0;
            fill_ptr_q    <= '0;
            rd_ptr_q      <= '0;
            discard_cnt_q <= '0;
            filled_q      <= '0;
        end else begin
            alloc_ptr_q   <= alloc_ptr_d;
            fill_ptr_q    <= fill_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            discard_cnt_q <= discard_cnt_d;
            filled_q      <= filled_d;
        end
    end

    riscv_if_prefetch_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk              (clk),
        .rstn             (rstn),
        .alloc_we         (issue),
        .alloc_idx        (alloc_idx),
        .alloc_pc         (if_nxt_pc),
        .alloc_misaligned (|if_nxt_pc[1:0]),
        .fill_we          (resp_fill & ~if_flush),
        .fill_idx         (fill_idx),
        .fill_parcel      (mem_rdata),
        .fill_fault       (mem_err),
        .rd_idx           (head_idx),
        .rd_entry         (head)
    );

    assign if_parcel_valid      = head_ok ? '1 : '0;
    assign if_parcel            = head_ok ? head.parcel : PARCEL_SIZE'(INSTR_NOP);
    assign if_parcel_pc         = head_ok ? head.pc : '0;
    assign if_parcel_misaligned = head_ok & head.misaligned;
    assign if_parcel_page_fault = head_ok & head.fault;

    // Responses must belong to an outstanding or discarded request.
    a_resp_expected: assert property (@(posedge clk) disable iff (!rstn)
        mem_rvalid |-> (inflight != '0 || discard_cnt_q != '0));

endmodule

// File: tb/tb_riscv_if_prefetch.sv
// Bench for riscv_if_prefetch: a bus model with a gated in-order response
// queue and a scoreboard of expected parcels checked on every pop.
module tb_riscv_if_prefetch;
    import riscv_mpsoc_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [63:0] if_nxt_pc = '0;
    logic        if_stall = 1'b0;
    logic        if_flush = 1'b0;
    logic        if_stall_nxt_pc;
    logic [31:0] if_parcel;
    logic [63:0] if_parcel_pc;
    logic [1:0]  if_parcel_valid;
    logic        if_parcel_misaligned;
    logic        if_parcel_page_fault;
    logic        mem_req;
    logic [63:0] mem_adr;
    logic        mem_ack = 1'b0;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;

    always #5 clk = ~clk;

    riscv_if_prefetch dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .if_nxt_pc            (if_nxt_pc),
        .if_stall             (if_stall),
        .if_flush             (if_flush),
        .if_stall_nxt_pc      (if_stall_nxt_pc),
        .if_parcel            (if_parcel),
        .if_parcel_pc         (if_parcel_pc),
        .if_parcel_valid      (if_parcel_valid),
        .if_parcel_misaligned (if_parcel_misaligned),
        .if_parcel_page_fault (if_parcel_page_fault),
        .mem_req              (mem_req),
        .mem_adr              (mem_adr),
        .mem_ack              (mem_ack),
        .mem_rvalid           (mem_rvalid),
        .mem_rdata            (mem_rdata),
        .mem_err              (mem_err)
    );

    typedef struct packed {
        logic [31:0] parcel;
        logic [63:0] pc;
        logic        mis;
        logic        fault;
    } exp_t;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] adr;
        logic        mis;
        logic        fault;
    } vec_t;

    exp_t        sb[$];
    logic [63:0] pend[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic        resp_en = 1'b0;
    logic [63:0] err_adr = 64'h1;
    logic        nx_mis = 1'b0;
    logic        nx_fault = 1'b0;
    logic        iss_s = 1'b0;
    logic [63:0] adr_s = '0;
    vec_t        tbl[6];

    function automatic logic [31:0] data_of(input logic [63:0] a);
        return a[31:0] ^ 32'h8000_0013;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Bus model: capture issue mid-cycle, answer in order when resp_en is set.
    always @(negedge clk) begin
        iss_s <= mem_req & mem_ack;
        adr_s <= mem_adr;
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend.delete();
            mem_rvalid <= 1'b0;
            mem_rdata  <= '0;
            mem_err    <= 1'b0;
        end else begin
            if (iss_s) pend.push_back(adr_s);
            if (resp_en && pend.size() != 0) begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= data_of(pend[0]);
                mem_err    <= (pend[0] == err_adr);
                pend.delete(0);
            end else begin
                mem_rvalid <= 1'b0;
            end
        end
    end

    // One clock: scoreboard work at negedge, return 1 time unit after posedge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (if_flush) begin
            sb.delete();
        end else begin
            if (if_parcel_valid != 2'b00) begin
                if (sb.size() == 0) begin
                    chk("stale_valid", 64'(if_parcel_valid), 64'h0);
                end else if (!if_stall) begin
                    e = sb.pop_front();
                    chk("pop_parcel", 64'(if_parcel), 64'(e.parcel));
                    chk("pop_pc", if_parcel_pc, e.pc);
                    chk("pop_flags", 64'({if_parcel_misaligned, if_parcel_page_fault}),
                        64'({e.mis, e.fault}));
                end
            end
            if (mem_req && mem_ack)
                sb.push_back('{data_of({if_nxt_pc[63:2], 2'b00}), if_nxt_pc, nx_mis, nx_fault});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [63:0] pc, input logic [63:0] exp_adr);
        int n = 0;
        if_nxt_pc = pc;
        mem_ack   = 1'b1;
        #1;
        while (if_stall_nxt_pc && n < 50) begin
            tick();
            n++;
            #1;
        end
        if (n >= 50) chk("issue_timeout", 64'(if_stall_nxt_pc), 64'h0);
        else chk("issue_adr", mem_adr, exp_adr);
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        for (int n = 0; n < 40; n++) begin
            #1;
            if (if_parcel_valid != 2'b00) return;
            tick();
        end
        chk(nm, 64'(if_parcel_valid), 64'h3);
    endtask

    task automatic drain(input int cycles);
        repeat (cycles) tick();
        chk("drain_empty", 64'(sb.size()), 64'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [63:0] base;

        tbl[0] = '{pc: 64'h8000_0002, adr: 64'h8000_0000, mis: 1'b1, fault: 1'b0};
        tbl[1] = '{pc: 64'h8000_0010, adr: 64'h8000_0010, mis: 1'b0, fault: 1'b1};
        tbl[2] = '{pc: 64'h8000_0014, adr: 64'h8000_0014, mis: 1'b0, fault: 1'b0};
        tbl[3] = '{pc: 64'h8000_0012, adr: 64'h8000_0010, mis: 1'b1, fault: 1'b1};
        tbl[4] = '{pc: 64'h8000_0023, adr: 64'h8000_0020, mis: 1'b1, fault: 1'b0};
        tbl[5] = '{pc: 64'h8000_0028, adr: 64'h8000_0028, mis: 1'b0, fault: 1'b0};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", 64'(mem_req), 64'h0);
        chk("rst_stall_nxt", 64'(if_stall_nxt_pc), 64'h1);
        chk("rst_valid", 64'(if_parcel_valid), 64'h0);
        chk("rst_parcel", 64'(if_parcel), 64'h13);
        chk("rst_pc", if_parcel_pc, 64'h0);
        chk("rst_flags", 64'({if_parcel_misaligned, if_parcel_page_fault}), 64'h0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // First fetch: 1-cycle response, parcel visible two cycles after issue.
        resp_en   = 1'b1;
        if_nxt_pc = 64'h8000_0000;
        mem_ack   = 1'b1;
        #1;
        chk("t1_mem_req", 64'(mem_req), 64'h1);
        chk("t1_stall_nxt", 64'(if_stall_nxt_pc), 64'h0);
        chk("t1_adr", mem_adr, 64'h8000_0000);
        tick();
        mem_ack = 1'b0;
        #1;
        chk("t1_no_bypass", 64'(if_parcel_valid), 64'h0);
        tick();
        #1;
        chk("t1_valid", 64'(if_parcel_valid), 64'h3);
        chk("t1_parcel", 64'(if_parcel), 64'h13);
        chk("t1_pc", if_parcel_pc, 64'h8000_0000);
        tick();
        #1;
        chk("t1_empty", 64'(if_parcel_valid), 64'h0);

        // Fill the queue while the fetch stage stalls.
        base      = 64'h8000_0100;
        if_stall  = 1'b1;
        mem_ack   = 1'b1;
        if_nxt_pc = base;
        cnt       = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (!if_stall_nxt_pc) begin
                chk("full_adr", mem_adr, base + 64'(4 * cnt));
                cnt++;
            end
            tick();
            if_nxt_pc = base + 64'(4 * cnt);
        end
        #1;
        chk("full_cnt", 64'(cnt), 64'h4);
        chk("full_mem_req", 64'(mem_req), 64'h0);
        chk("full_stall_nxt", 64'(if_stall_nxt_pc), 64'h1);
        if_stall = 1'b0;
        #1;
        chk("full_head_valid", 64'(if_parcel_valid), 64'h3);
        chk("full_head_pc", if_parcel_pc, base);
        tick();
        #1;
        chk("full_slot_freed", 64'(mem_req), 64'h1);
        chk("full_pop_order", if_parcel_pc, base + 64'h4);
        tick();
        mem_ack = 1'b0;
        drain(10);

        // Flush with three requests in flight.
        resp_en = 1'b0;
        issue(64'h8000_0200, 64'h8000_0200);
        issue(64'h8000_0204, 64'h8000_0204);
        issue(64'h8000_0208, 64'h8000_0208);
        if_flush = 1'b1;
        #1;
        chk("fl3_mem_req", 64'(mem_req), 64'h0);
        chk("fl3_valid", 64'(if_parcel_valid), 64'h0);
        tick();
        if_flush = 1'b0;
        issue(64'h8000_1000, 64'h8000_1000);
        #1;
        chk("fl3_discard_blocks", 64'(mem_req), 64'h0);
        resp_en = 1'b1;
        wait_valid("fl3_timeout");
        chk("fl3_first_pc", if_parcel_pc, 64'h8000_1000);
        chk("fl3_first_parcel", 64'(if_parcel), 64'(data_of(64'h8000_1000)));
        drain(6);

        // Flush in the same cycle as a response, two in flight.
        resp_en = 1'b0;
        issue(64'h8000_0300, 64'h8000_0300);
        issue(64'h8000_0304, 64'h8000_0304);
        resp_en = 1'b1;
        tick();
        resp_en  = 1'b0;
        if_flush = 1'b1;
        #1;
        chk("fl2_rvalid_in_flush", 64'(mem_rvalid), 64'h1);
        chk("fl2_valid", 64'(if_parcel_valid), 64'h0);
        tick();
        if_flush = 1'b0;
        resp_en  = 1'b1;
        issue(64'h8000_0400, 64'h8000_0400);
        wait_valid("fl2_timeout");
        chk("fl2_first_pc", if_parcel_pc, 64'h8000_0400);
        chk("fl2_first_parcel", 64'(if_parcel), 64'(data_of(64'h8000_0400)));
        drain(6);

        // Table: misaligned PCs and bus errors.
        err_adr = 64'h8000_0010;
        for (int i = 0; i < 6; i++) begin
            nx_mis   = tbl[i].mis;
            nx_fault = tbl[i].fault;
            issue(tbl[i].pc, tbl[i].adr);
        end
        nx_mis   = 1'b0;
        nx_fault = 1'b0;
        drain(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_if_prefetch.md
Name: riscv_if_prefetch

Overview:
- Parcel prefetch buffer between the instruction bus/cache request port and the instruction fetch stage.
- Issues in-order fetch requests at the fetch stage's if_nxt_pc.
- Tags each request with its PC and exception flags, and queues responses until the fetch stage can take them.
- Drops stale in-flight responses after any flush or predicted branch (if_flush).

Parameters:
- XLEN, 64, address/PC width.
- PARCEL_SIZE, 32, parcel (bus read data) width in bits; multiple of 16.
- DEPTH, 4, queue entries; power of two, ≥2.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- if_nxt_pc  in  XLEN  next PC to fetch, from fetch stage.
- if_stall  in  1  fetch stage cannot accept a parcel this cycle.
- if_flush  in  1  discard queue and in-flight requests.
- if_stall_nxt_pc  out  1  fetch stage must hold if_nxt_pc.
- if_parcel  out  PARCEL_SIZE  head parcel.
- if_parcel_pc  out  XLEN  PC of head parcel.
- if_parcel_valid  out  PARCEL_SIZE/16  all-ones when the head parcel is valid, else 0.
- if_parcel_misaligned  out  1  head request PC was not 4-byte aligned.
- if_parcel_page_fault  out  1  head response returned a bus error.
- mem_req  out  1  fetch request valid.
- mem_adr  out  XLEN  request address, bits[1:0] forced to 0.
- mem_ack  in  1  request accepted this cycle.
- mem_rvalid  in  1  read response valid; responses arrive in request order.
- mem_rdata  in  PARCEL_SIZE  response data.
- mem_err  in  1  response error, qualified by mem_rvalid.

Behaviour:
- Storage: DEPTH entries of {parcel, pc, misaligned, fault, filled}.
- Three pointers, log2(DEPTH)+1 bits each, wrapping mod 2*DEPTH:
  - alloc_ptr advances on issue;
  - fill_ptr advances on an accepted (non-discarded) response;
  - rd_ptr advances on pop.
- Derived counts:
  - occupancy = alloc_ptr−rd_ptr;
  - inflight = alloc_ptr−fill_ptr;
  - discard_cnt register, 0..DEPTH.
- Issue:
  - mem_req = ~if_flush & (occupancy + discard_cnt < DEPTH); mem_adr = {if_nxt_pc[XLEN-1:2],2'b00}.
  - On mem_req&mem_ack, allocate entry at alloc_ptr: pc=if_nxt_pc, misaligned=|if_nxt_pc[1:0], filled=0.
  - if_stall_nxt_pc = ~(mem_req & mem_ack); combinational, same cycle.
- Response:
  - On mem_rvalid with discard_cnt≠0: drop it and decrement discard_cnt.
  - Otherwise write entry at fill_ptr: parcel=mem_rdata, fault=mem_err, filled=1; then advance fill_ptr.
  - A response with inflight=0 and discard_cnt=0 is a protocol violation; assertion only.
- Output:
  - Head entry (rd_ptr) is presented when occupancy≠0, the head is filled, and ~if_flush.
  - if_parcel_valid = all-ones under that condition, else 0.
  - When not valid, if_parcel=INSTR_NOP and both flags are 0.
  - Pop on if_parcel_valid≠0 & ~if_stall.
  - Latency: response in cycle N is visible at the output in N+1; no bypass.
- Flush (if_flush=1):
  - Next cycle: alloc_ptr=fill_ptr=rd_ptr=0 and all filled bits cleared.
  - discard_cnt = discard_cnt + inflight − (1 if a response arrives this cycle).
  - No issue or pop in the flush cycle.
  - Back-to-back flushes accumulate discard_cnt correctly.
- Full: occupancy+discard_cnt=DEPTH blocks issue and raises if_stall_nxt_pc; pop in the same cycle frees the slot from the next cycle.
- Simultaneous issue, response and pop in one cycle are all legal; each pointer advances independently.
- Reset (async): pointers=0, discard_cnt=0, filled=0.
  - Outputs: mem_req=0, if_stall_nxt_pc=1, if_parcel_valid=0, if_parcel=INSTR_NOP, if_parcel_pc=0, flags=0.
  - Reset mid-transaction loses in-flight responses; the bus is reset together with this block.

Decomposition:
- INSTR_NOP comes from riscv_mpsoc_pkg.
- Add PF_DEPTH_DEFAULT to riscv_mpsoc_pkg.
- Add a packed struct pf_entry_t {parcel, pc, misaligned, fault} to riscv_mpsoc_pkg.
- Natural sub-module: riscv_if_prefetch_ram, a DEPTH×pf_entry_t register file with one alloc-write port, one fill-write port and an async read.

Test Plan:
- Reset release, if_nxt_pc=0x8000_0000, mem_ack=1, 1-cycle response 0x00000013 → parcel pc 0x8000_0000 is valid 2 cycles after the request; if_stall_nxt_pc=0 in the issue cycle.
- if_stall held, mem_ack=1, DEPTH=4 → exactly 4 requests (0x…00,04,08,0C), then mem_req=0 and if_stall_nxt_pc=1.
  - Release if_stall → parcels pop in PC order, one per cycle.
- 3 requests in flight, if_flush pulsed, new PC 0x8000_1000 → 3 old responses dropped (discard_cnt 3→0); the first visible parcel has pc 0x8000_1000.
- if_flush in the same cycle as a response, inflight=2 → discard_cnt=1; no stale parcel is ever valid.
- if_nxt_pc=0x8000_0002 → mem_adr=0x8000_0000; the parcel presents with if_parcel_misaligned=1.
- Response with mem_err=1 at pc 0x8000_0010 → if_parcel_page_fault=1 on that parcel only; the next parcel has 0.
